// File: rtl/data_cache_responder_pkg.sv
`default_nettype none
// ============================================================================
// Module : data_cache_responder_pkg
// Brief  : Shared types, constants and byte-merge helper for the data cache.
// Rev    : 1.0 - initial release
// ============================================================================
package data_cache_responder_pkg;

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        LOOKUP     = 3'd1,
        REFILL     = 3'd2,
        WRITE_THRU = 3'd3,
        RESPOND    = 3'd4
    } dcache_state_e;

    localparam int DCACHE_WORD_BYTES = 4;

    function automatic logic [DCACHE_WORD_BYTES*8-1:0] dcache_merge(
        input logic [DCACHE_WORD_BYTES*8-1:0] old_word,
        input logic [DCACHE_WORD_BYTES*8-1:0] new_word,
        input logic [DCACHE_WORD_BYTES-1:0]   byte_en
    );
        logic [DCACHE_WORD_BYTES*8-1:0] merged;
        merged = old_word;
        for (int b = 0; b < DCACHE_WORD_BYTES; b++) begin
            if (byte_en[b]) merged[8*b +: 8] = new_word[8*b +: 8];
        end
        return merged;
    endfunction

endpackage
`default_nettype wire

// File: rtl/data_cache_responder_if.sv
`default_nettype none
// ============================================================================
// Module : data_cache_responder_if
// Brief  : Load/store request port plus word-serial memory port of the cache.
//          Statistics outputs exist only when DCACHE_STATS_EN is defined.
// Rev    : 1.0 - initial release
// ============================================================================
interface data_cache_responder_if;
    import data_cache_responder_pkg::*;

    logic [31:0]                  i_address;
    logic                         i_read;
    logic                         i_write;
    logic [DCACHE_WORD_BYTES-1:0] i_byte_en;
    logic [31:0]                  i_wdata;
    logic [31:0]                  o_rdata;
    logic                         o_hit;
    logic [31:0]                  o_mem_address;
    logic                         o_mem_read;
    logic                         o_mem_write;
    logic [DCACHE_WORD_BYTES-1:0] o_mem_byte_en;
    logic [31:0]                  o_mem_wdata;
    logic [31:0]                  i_mem_rdata;
    logic                         i_mem_ready;
`ifdef DCACHE_STATS_EN
    logic [31:0]                  o_read_hits;
    logic [31:0]                  o_read_misses;
    logic [31:0]                  o_writes;
`endif

    modport slave (
        input  i_address, i_read, i_write, i_byte_en, i_wdata,
        input  i_mem_rdata, i_mem_ready,
        output o_rdata, o_hit,
        output o_mem_address, o_mem_read, o_mem_write, o_mem_byte_en, o_mem_wdata
`ifdef DCACHE_STATS_EN
        , output o_read_hits, o_read_misses, o_writes
`endif
    );

    modport master (
        output i_address, i_read, i_write, i_byte_en, i_wdata,
        output i_mem_rdata, i_mem_ready,
        input  o_rdata, o_hit,
        input  o_mem_address, o_mem_read, o_mem_write, o_mem_byte_en, o_mem_wdata
`ifdef DCACHE_STATS_EN
        , input o_read_hits, o_read_misses, o_writes
`endif
    );

endinterface
`default_nettype wire

// File: rtl/data_cache_responder_line_array.sv
`default_nettype none
// ============================================================================
// Module : dcache_line_array
// Brief  : Tag/valid/data storage, combinational read by index, synchronous
//          word and tag writes, valid bits cleared asynchronously on reset.
// Rev    : 1.0 - initial release
// ============================================================================
module dcache_line_array
    import data_cache_responder_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4,
    parameter int IDX_W      = $clog2(SETS),
    parameter int OFF_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = 32 - 2 - OFF_W - IDX_W
) (
    input  wire logic                           clk,
    input  wire logic                           rst,
    input  wire logic [IDX_W-1:0]               i_index,
    input  wire logic [OFF_W-1:0]               i_rd_offset,
    output logic                                o_rd_valid,
    output logic [TAG_W-1:0]                    o_rd_tag,
    output logic [DCACHE_WORD_BYTES*8-1:0]      o_rd_word,
    input  wire logic                           i_word_we,
    input  wire logic [OFF_W-1:0]               i_wr_offset,
    input  wire logic [DCACHE_WORD_BYTES*8-1:0] i_wr_word,
    input  wire logic                           i_tag_we,
    input  wire logic [TAG_W-1:0]               i_wr_tag
);

    localparam int c_WORD_W = DCACHE_WORD_BYTES * 8;

    logic [c_WORD_W-1:0] r_data [SETS*LINE_WORDS];
    logic [TAG_W-1:0]    r_tag  [SETS];
    logic [SETS-1:0]     r_valid;

    assign o_rd_valid = r_valid[i_index];
    assign o_rd_tag   = r_tag[i_index];
    assign o_rd_word  = r_data[{i_index, i_rd_offset}];

    always_ff @(posedge clk) begin
        if (i_word_we) r_data[{i_index, i_wr_offset}] <= i_wr_word;
        if (i_tag_we)  r_tag[i_index]                 <= i_wr_tag;
    end

    // Only the valid bits need reset; stale tag/data are masked by them.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
        end else if (i_tag_we) begin
            r_valid[i_index] <= 1'b1;
        end
    end

endmodule
`default_nettype wire

// File: rtl/data_cache_responder.sv
`default_nettype none
// ============================================================================
// Module : data_cache_responder
// Brief  : Direct-mapped, write-through, no-write-allocate data cache with a
//          word-serial refill port. Define DCACHE_STATS_EN for hit/miss counters.
// Rev    : 1.0 - initial release
// ============================================================================
module data_cache_responder
    import data_cache_responder_pkg::*;
#(
    parameter int SETS       = 64,
    parameter int LINE_WORDS = 4
) (
    input  wire logic              i_clk,
    input  wire logic              i_reset,
    data_cache_responder_if.slave  bus
);

    localparam int OFF_W    = $clog2(LINE_WORDS);
    localparam int IDX_W    = $clog2(SETS);
    localparam int TAG_W    = 32 - 2 - OFF_W - IDX_W;
    localparam int c_WORD_W = DCACHE_WORD_BYTES * 8;

    dcache_state_e                r_state;
    dcache_state_e                w_state_next;
    logic [31:2]                  r_addr;
    logic                         r_is_write;
    logic [DCACHE_WORD_BYTES-1:0] r_byte_en;
    logic [c_WORD_W-1:0]          r_wdata;
    logic [OFF_W-1:0]             r_count;
    logic [c_WORD_W-1:0]          r_rdata;

    logic [OFF_W-1:0]             w_offset;
    logic [IDX_W-1:0]             w_index;
    logic [TAG_W-1:0]             w_tag;
    logic                         w_line_valid;
    logic [TAG_W-1:0]             w_line_tag;
    logic [c_WORD_W-1:0]          w_line_word;
    logic                         w_lookup_hit;
    logic                         w_refill_last;
    logic                         w_req;
    logic                         w_unused;

    logic                         w_word_we;
    logic [OFF_W-1:0]             w_wr_offset;
    logic [c_WORD_W-1:0]          w_wr_word;
    logic                         w_tag_we;
    logic                         w_hit;
    logic                         w_mem_read;
    logic                         w_mem_write;
    logic [31:0]                  w_mem_address;
    logic [DCACHE_WORD_BYTES-1:0] w_mem_byte_en;
    logic [c_WORD_W-1:0]          w_mem_wdata;

    assign w_offset      = r_addr[2 +: OFF_W];
    assign w_index       = r_addr[2+OFF_W +: IDX_W];
    assign w_tag         = r_addr[31 -: TAG_W];
    assign w_lookup_hit  = w_line_valid && (w_line_tag == w_tag);
    assign w_refill_last = (r_count == OFF_W'(LINE_WORDS - 1));
    assign w_req         = bus.i_read || bus.i_write;
    assign w_unused      = ^bus.i_address[1:0];

    dcache_line_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS)
    ) u_line_array (
        .clk         (i_clk),
        .rst         (i_reset),
        .i_index     (w_index),
        .i_rd_offset (w_offset),
        .o_rd_valid  (w_line_valid),
        .o_rd_tag    (w_line_tag),
        .o_rd_word   (w_line_word),
        .i_word_we   (w_word_we),
        .i_wr_offset (w_wr_offset),
        .i_wr_word   (w_wr_word),
        .i_tag_we    (w_tag_we),
        .i_wr_tag    (w_tag)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) r_state <= IDLE;
        else         r_state <= w_state_next;
    end

    always_comb begin
        w_state_next  = r_state;
        w_word_we     = 1'b0;
        w_wr_offset   = w_offset;
        w_wr_word     = w_line_word;
        w_tag_we      = 1'b0;
        w_hit         = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_mem_address = '0;
        w_mem_byte_en = '0;
        w_mem_wdata   = '0;
        case (r_state)
            IDLE: begin
                if (w_req) w_state_next = LOOKUP;
            end
            LOOKUP: begin
                if (r_is_write) begin
                    w_state_next = WRITE_THRU;
                    if (w_lookup_hit) begin
                        w_word_we = 1'b1;
                        w_wr_word = dcache_merge(w_line_word, r_wdata, r_byte_en);
                    end
                end else if (w_lookup_hit) begin
                    w_state_next = RESPOND;
                end else begin
                    w_state_next = REFILL;
                end
            end
            REFILL: begin
                w_mem_read    = 1'b1;
                w_mem_address = {w_tag, w_index, r_count, 2'b00};
                if (bus.i_mem_ready) begin
                    w_word_we   = 1'b1;
                    w_wr_offset = r_count;
                    w_wr_word   = bus.i_mem_rdata;
                    // Tag and valid are committed only with the final word.
                    if (w_refill_last) begin
                        w_tag_we     = 1'b1;
                        w_state_next = RESPOND;
                    end
                end
            end
            WRITE_THRU: begin
                w_mem_write   = 1'b1;
                w_mem_address = {r_addr, 2'b00};
                w_mem_byte_en = r_byte_en;
                w_mem_wdata   = r_wdata;
                if (bus.i_mem_ready) w_state_next = RESPOND;
            end
            RESPOND: begin
                w_hit        = 1'b1;
                w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_addr     <= '0;
            r_is_write <= 1'b0;
            r_byte_en  <= '0;
            r_wdata    <= '0;
            r_count    <= '0;
            r_rdata    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req) begin
                        r_addr     <= bus.i_address[31:2];
                        r_is_write <= bus.i_write;
                        r_byte_en  <= bus.i_byte_en;
                        r_wdata    <= bus.i_wdata;
                    end
                end
                LOOKUP: begin
                    r_count <= '0;
                    if (!r_is_write && w_lookup_hit) r_rdata <= w_line_word;
                end
                REFILL: begin
                    if (bus.i_mem_ready) begin
                        r_count <= r_count + OFF_W'(1);
                        if (r_count == w_offset) r_rdata <= bus.i_mem_rdata;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_rdata       = r_rdata;
    assign bus.o_hit         = w_hit;
    assign bus.o_mem_address = w_mem_address;
    assign bus.o_mem_read    = w_mem_read;
    assign bus.o_mem_write   = w_mem_write;
    assign bus.o_mem_byte_en = w_mem_byte_en;
    assign bus.o_mem_wdata   = w_mem_wdata;

`ifdef DCACHE_STATS_EN
    logic [31:0] r_read_hits;
    logic [31:0] r_read_misses;
    logic [31:0] r_writes;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_read_hits   <= '0;
            r_read_misses <= '0;
            r_writes      <= '0;
        end else if (r_state == LOOKUP) begin
            if (r_is_write) begin
                if (r_writes != 32'hFFFF_FFFF) r_writes <= r_writes + 32'd1;
            end else if (w_lookup_hit) begin
                if (r_read_hits != 32'hFFFF_FFFF) r_read_hits <= r_read_hits + 32'd1;
            end else begin
                if (r_read_misses != 32'hFFFF_FFFF) r_read_misses <= r_read_misses + 32'd1;
            end
        end
    end

    assign bus.o_read_hits   = r_read_hits;
    assign bus.o_read_misses = r_read_misses;
    assign bus.o_writes      = r_writes;
`endif

endmodule
`default_nettype wire

// File: doc/data_cache_responder.md
Name: data_cache_responder

Overview:
- Responder end of the load/store-to-data-cache handshake; serves word loads and stores issued by the load/store unit.
- Direct-mapped, write-through, no-write-allocate cache.
- Refills lines from main memory through a word-serial valid/ready port.
- Sits between the load/store combo and the memory/bus model.

Parameters:
SETS, 64, number of lines (power of two, >=2)
LINE_WORDS, 4, 32-bit words per line (power of two, >=2)

Ports:
i_clk  in  1  clock
i_reset  in  1  asynchronous active-high reset
i_address  in  32  byte address from load/store unit (word-aligned; bits [1:0] ignored)
i_read  in  1  load request, held until o_hit
i_write  in  1  store request, held until o_hit
i_byte_en  in  4  store byte lanes
i_wdata  in  32  store data
o_rdata  out  32  load data, valid while o_hit=1
o_hit  out  1  one-cycle completion pulse
o_mem_address  out  32  word address to memory
o_mem_read  out  1  memory read strobe
o_mem_write  out  1  memory write strobe
o_mem_byte_en  out  4  memory write lanes
o_mem_wdata  out  32  memory write data
i_mem_rdata  in  32  memory read data
i_mem_ready  in  1  memory accepts write / returns read data this cycle

Behaviour:
- Address split: offset = addr[2+:log2(LINE_WORDS)], index = next log2(SETS) bits, tag = remaining upper bits.
- Reset (async, any state): all valid bits 0; FSM to IDLE; o_hit, o_mem_read, o_mem_write = 0; o_rdata, o_mem_address, o_mem_wdata, o_mem_byte_en = 0. A refill in progress is abandoned; the line stays invalid.
- FSM states: IDLE, LOOKUP, REFILL, WRITE_THRU, RESPOND.
- IDLE:
  - i_read or i_write high: latch request, go to LOOKUP.
  - Both high: treated as a write.
- LOOKUP (1 cycle), compare tag and valid:
  - Read hit: o_rdata <= word; go to RESPOND.
  - Read miss: go to REFILL with word counter 0.
  - Write (hit or miss): on hit, merge i_wdata into the line per i_byte_en. Go to WRITE_THRU.
- REFILL:
  - o_mem_read=1, o_mem_address = {tag,index,counter,2'b00}.
  - Each cycle with i_mem_ready: store i_mem_rdata into the data array and increment the counter.
  - After word LINE_WORDS-1: write tag, set valid, o_rdata <= requested word; go to RESPOND.
  - Counter wraps to 0 at exit.
  - i_mem_ready low stalls with strobes held and the address stable.
- WRITE_THRU: o_mem_write=1 with the latched address, data and byte_en, held until i_mem_ready; then go to RESPOND. A write miss does not touch the array.
- RESPOND: o_hit=1 for exactly one cycle, then IDLE. The requester drops or changes the request the cycle after o_hit. IDLE ignores the request during the RESPOND cycle, so no double-accept.
- Latency: read hit = o_hit 2 cycles after request. Read miss = 2 + LINE_WORDS×(memory wait+1) cycles. Write = 2 + memory wait + 1 cycles.
- Memory strobes are mutually exclusive; never asserted in IDLE, LOOKUP or RESPOND.
- Request changes mid-operation are not allowed; the latched copy is used.

Optional Feature:
DCACHE_STATS_EN:
- Defined: adds outputs o_read_hits[31:0], o_read_misses[31:0], o_writes[31:0].
  - Counters increment on LOOKUP outcome and saturate at 32'hFFFF_FFFF.
  - Reset to 0.
- Undefined: ports and counters are absent; behaviour otherwise identical.

Decomposition:
- pkg_defines gains:
  - enum dcache_state_e (IDLE, LOOKUP, REFILL, WRITE_THRU, RESPOND).
  - localparam DCACHE_WORD_BYTES=4.
  - Function dcache_merge(old, new, byte_en) returning the merged word.
- Sub-module dcache_line_array:
  - Holds the tag/valid/data arrays.
  - Combinational read by index.
  - Synchronous word write, tag write and valid set.
  - Async clear of valid on reset.
- The top holds the FSM, latches and memory port.

Test Plan:
- Cold read 0x0000_0040, memory returns words A0..A3 with ready always high -> 4 reads at 0x40,0x44,0x48,0x4C; o_hit with o_rdata=A0; then read 0x48 hits, o_hit 2 cycles after request, o_rdata=A2, no memory strobe.
- Store 0x0000_0044, data 0xDEADBEEF, byte_en 4'b0011 after a line fill where word=0x11223344 -> memory write lanes 0011; later read 0x44 hits with 0x1122BEEF.
- Store miss to 0x0000_1000 -> memory write issued, no refill; subsequent read 0x1000 misses and refills.
- Conflict: read 0x0000_0040 then 0x0000_0040 + SETS×LINE_WORDS×4 -> second misses and evicts; re-read 0x40 misses again.
- Reset asserted on the 2nd refill word, ready held low for 3 cycles -> all outputs 0 immediately; after release, read 0x40 misses again.
- With DCACHE_STATS_EN: 1 miss, 3 hits, 2 writes -> counters read 1/3/2.
